// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings, beat indices
// and the status-word packing helper used by the result serializer.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OUT_W  = 16;
  localparam int OP_W   = 6;

  // Opcode encodings produced by the ALU.
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_XOR   = 6'b000100;
  localparam logic [5:0] OP_SLL   = 6'b000101;
  localparam logic [5:0] OP_SRL   = 6'b000110;
  localparam logic [5:0] OP_SRA   = 6'b000111;
  localparam logic [5:0] OP_SLT   = 6'b001000;
  localparam logic [5:0] OP_SLTU  = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001110;
  localparam logic [5:0] OP_SLTIU = 6'b001111;
  localparam logic [5:0] OP_SLLI  = 6'b010000;
  localparam logic [5:0] OP_SRLI  = 6'b010001;

  // Beat index within one serialized entry.
  localparam logic [1:0] BEAT_LO   = 2'd0;
  localparam logic [1:0] BEAT_HI   = 2'd1;
  localparam logic [1:0] BEAT_STAT = 2'd2;

  // Status beat layout: {2'b00, op, 5'b0, neg, zero, carry}.
  function automatic logic [15:0] status_word(input logic [5:0]  op,
                                              input logic        carry,
                                              input logic [31:0] result);
    logic neg;
    logic zero;
    neg  = result[31];
    zero = (result == 32'h0000_0000);
    return {2'b00, op, 5'b00000, neg, zero, carry};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding packed {op, carry, result} entries.
// Pointers wrap explicitly at DEPTH-1 so any DEPTH >= 2 works.
module result_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; simultaneous push/pop keeps count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// ALU result serializer: buffers ALU results and streams each one as
// OUT_W-bit beats (low half, high half) over a valid/ready handshake.
// Optional feature macro STATUS_BEAT_EN adds a third status beat per entry
// carrying {2'b00, op, 5'b0, neg, zero, carry}.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OUT_W  = alu_pkg::OUT_W,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_carry,
  input  logic [OP_W-1:0]            in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int ENTRY_W = OP_W + 1 + DATA_W;
`ifdef STATUS_BEAT_EN
  localparam logic [1:0] LAST_BEAT = BEAT_STAT;
`else
  localparam logic [1:0] LAST_BEAT = BEAT_HI;
`endif

  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] head_s;
  logic [OP_W-1:0]    head_op_s;
  logic               head_carry_s;
  logic [DATA_W-1:0]  head_result_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;
  logic               beat_fire_s;
  logic               is_last_s;
  logic [1:0]         beat_q, beat_d;

  assign wr_entry_s    = {in_op, in_carry, in_result};
  assign head_op_s     = head_s[ENTRY_W-1 -: OP_W];
  assign head_carry_s  = head_s[DATA_W];
  assign head_result_s = head_s[DATA_W-1:0];

  // Handshake qualifiers derive from registered occupancy only (no ready bypass).
  assign in_ready    = !fifo_full_s;
  assign out_valid   = !fifo_empty_s;
  assign push_s      = in_valid && in_ready;
  assign beat_fire_s = out_valid && out_ready;
  assign is_last_s   = (beat_q == LAST_BEAT);
  assign pop_s       = beat_fire_s && is_last_s;

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .wr_data_i (wr_entry_s),
    .rd_data_o (head_s),
    .count_o   (count),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  // Beat index advances on each accepted beat and wraps after the last one.
  always_comb begin
    beat_d = beat_q;
    if (beat_fire_s) begin
      if (is_last_s) begin
        beat_d = BEAT_LO;
      end else begin
        beat_d = beat_q + 2'd1;
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // Beat index register; reset discards any partly sent entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= BEAT_LO;
    end else begin
      beat_q <= beat_d;
    end
  end

`ifndef STATUS_BEAT_EN
  // The opcode is only consumed by the status beat.
  logic unused_op_s;
  assign unused_op_s = ^head_op_s;
`endif

  // Output mux: head entry's current beat, all-zero while empty.
  always_comb begin
    out_data  = {OUT_W{1'b0}};
    out_carry = 1'b0;
    out_last  = 1'b0;
    if (!fifo_empty_s) begin
      out_carry = head_carry_s;
      out_last  = is_last_s;
      case (beat_q)
        BEAT_LO: out_data = head_result_s[OUT_W-1:0];
        BEAT_HI: out_data = head_result_s[DATA_W-1:OUT_W];
`ifdef STATUS_BEAT_EN
        BEAT_STAT: out_data = status_word(head_op_s, head_carry_s, head_result_s);
`endif
        default: out_data = {OUT_W{1'b0}};
      endcase
    end else begin
      out_data  = {OUT_W{1'b0}};
      out_carry = 1'b0;
      out_last  = 1'b0;
    end
  end

endmodule
